// File: rtl/mag_cmp_pipe.sv
// Pipelined SPLIT-ary magnitude comparator tree with per-operation signed/unsigned
// mode, optional register after each tree level, valid/ready backpressure and a tag.
module mag_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 2,
    parameter logic [$clog2(WIDTH)/$clog2(SPLIT)-1:0] REGS = '1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic [WIDTH-1:0] val,
    input  logic [WIDTH-1:0] rfr,
    input  logic             sgn,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic             grt,
    output logic             lst,
    output logic             eq,
    output logic [TAG_W-1:0] o_tag
);

    localparam int LEVELS = $clog2(WIDTH) / $clog2(SPLIT);

    // Leaves and nodes share one primitive: a SPLIT-bit unsigned compare
    // returning {a > b, a < b}.
    function automatic logic [1:0] grp_cmp(input logic [SPLIT-1:0] a,
                                           input logic [SPLIT-1:0] b);
        return {a > b, a < b};
    endfunction

    for (genvar l = 0; l < LEVELS; l++) begin : lvl
        localparam int NI = WIDTH / (SPLIT ** l);
        localparam int NO = NI / SPLIT;

        logic [NI-1:0]    a_in;
        logic [NI-1:0]    b_in;
        logic [NO-1:0]    g_c;
        logic [NO-1:0]    l_c;
        logic [NO-1:0]    g_out;
        logic [NO-1:0]    l_out;
        logic             vld_in;
        logic             vld_out;
        logic             rdy_in;
        logic             rdy_out;
        logic [TAG_W-1:0] tag_in;
        logic [TAG_W-1:0] tag_out;

        // Signed mode flips both MSBs so the whole tree stays an unsigned compare.
        if (l == 0) begin : src
            assign a_in   = {val[WIDTH-1] ^ sgn, val[WIDTH-2:0]};
            assign b_in   = {rfr[WIDTH-1] ^ sgn, rfr[WIDTH-2:0]};
            assign vld_in = i_vld;
            assign tag_in = i_tag;
        end else begin : chain
            assign a_in   = lvl[l-1].g_out;
            assign b_in   = lvl[l-1].l_out;
            assign vld_in = lvl[l-1].vld_out;
            assign tag_in = lvl[l-1].tag_out;
        end

        if (l == LEVELS - 1) begin : sink
            assign rdy_out = o_rdy;
        end else begin : fwd
            assign rdy_out = lvl[l+1].rdy_in;
        end

        always_comb begin
            g_c = '0;
            l_c = '0;
            for (int j = 0; j < NO; j++) begin
                {g_c[j], l_c[j]} = grp_cmp(a_in[j*SPLIT +: SPLIT], b_in[j*SPLIT +: SPLIT]);
            end
        end

        // Stage boundary after level l
        if (REGS[l]) begin : reg_stage
            logic             vld_p;
            logic [NO-1:0]    g_p;
            logic [NO-1:0]    l_p;
            logic [TAG_W-1:0] tag_p;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= 1'b0;
                    g_p   <= '0;
                    l_p   <= '0;
                    tag_p <= '0;
                end else if (rdy_in) begin
                    vld_p <= vld_in;
                    if (vld_in) begin
                        g_p   <= g_c;
                        l_p   <= l_c;
                        tag_p <= tag_in;
                    end
                end
            end

            assign rdy_in  = ~vld_p | rdy_out;
            assign vld_out = vld_p;
            assign g_out   = g_p;
            assign l_out   = l_p;
            assign tag_out = tag_p;
        end else begin : pass
            assign rdy_in  = rdy_out;
            assign vld_out = vld_in;
            assign g_out   = g_c;
            assign l_out   = l_c;
            assign tag_out = tag_in;
        end
    end

    assign i_rdy = lvl[0].rdy_in;
    assign o_vld = lvl[LEVELS-1].vld_out;
    assign grt   = lvl[LEVELS-1].g_out[0];
    assign lst   = lvl[LEVELS-1].l_out[0];
    // Qualified by o_vld so an empty or freshly reset pipe reports no result.
    assign eq    = o_vld & ~grt & ~lst;
    assign o_tag = lvl[LEVELS-1].tag_out;

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// Directed bench for mag_cmp_pipe: 8-bit, SPLIT=2, fully registered instance
// plus a combinational (REGS=0) instance checked against a behavioural compare.
module tb_mag_cmp_pipe;

    localparam logic [2:0] GRT = 3'b100;
    localparam logic [2:0] LST = 3'b010;
    localparam logic [2:0] EQ  = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_vld, i_rdy, o_vld, o_rdy, sgn, grt, lst, eq;
    logic [7:0] val, rfr;
    logic [3:0] i_tag, o_tag;

    logic       c_ivld, c_irdy, c_ovld, c_ordy, c_sgn, c_grt, c_lst, c_eq;
    logic [7:0] c_val, c_rfr;
    logic [3:0] c_itag, c_otag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mag_cmp_pipe #(.WIDTH(8), .SPLIT(2), .REGS(3'b111), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .val(val), .rfr(rfr),
        .sgn(sgn), .i_tag(i_tag), .o_vld(o_vld), .o_rdy(o_rdy), .grt(grt),
        .lst(lst), .eq(eq), .o_tag(o_tag)
    );

    mag_cmp_pipe #(.WIDTH(8), .SPLIT(2), .REGS(3'b000), .TAG_W(4)) u_comb (
        .clk(clk), .rst(rst), .i_vld(c_ivld), .i_rdy(c_irdy), .val(c_val), .rfr(c_rfr),
        .sgn(c_sgn), .i_tag(c_itag), .o_vld(c_ovld), .o_rdy(c_ordy), .grt(c_grt),
        .lst(c_lst), .eq(c_eq), .o_tag(c_otag)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] v, input logic [7:0] r, input logic s, input logic [3:0] t);
        i_vld = 1'b1;
        val   = v;
        rfr   = r;
        sgn   = s;
        i_tag = t;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] t4_exp [4];
        logic [2:0] exp;
        t4_exp = '{LST, LST, EQ, GRT};

        rst = 1'b1; i_vld = 1'b0; o_rdy = 1'b1; val = '0; rfr = '0; sgn = 1'b0; i_tag = '0;
        c_ivld = 1'b0; c_ordy = 1'b0; c_val = '0; c_rfr = '0; c_sgn = 1'b0; c_itag = '0;

        // reset state
        tick; tick;
        check("rst_ovld", o_vld, 0);
        check("rst_res", {grt, lst, eq}, 3'b000);
        check("rst_tag", o_tag, 0);
        check("rst_irdy", i_rdy, 1);
        rst = 1'b0;
        tick;
        check("post_rst_irdy", i_rdy, 1);
        check("post_rst_ovld", o_vld, 0);

        // 0x80 vs 0x7F unsigned then signed, latency 3
        op(8'h80, 8'h7F, 1'b0, 4'd1); tick;
        op(8'h80, 8'h7F, 1'b1, 4'd2); tick;
        i_vld = 1'b0;
        check("lat_early_ovld", o_vld, 0);
        tick;
        check("u80_ovld", o_vld, 1);
        check("u80_res", {grt, lst, eq}, GRT);
        check("u80_tag", o_tag, 1);
        tick;
        check("s80_ovld", o_vld, 1);
        check("s80_res", {grt, lst, eq}, LST);
        check("s80_tag", o_tag, 2);

        // equality, then -1 vs -2 signed
        op(8'hA5, 8'hA5, 1'b0, 4'd3); tick;
        check("bubble_ovld", o_vld, 0);
        op(8'hFF, 8'hFE, 1'b1, 4'd4); tick;
        i_vld = 1'b0; tick;
        check("eq_res", {grt, lst, eq}, EQ);
        check("eq_tag", o_tag, 3);
        tick;
        check("neg_res", {grt, lst, eq}, GRT);
        check("neg_tag", o_tag, 4);

        // four back-to-back ops
        for (int k = 0; k < 4; k++) begin
            op(8'(k), 8'd2, 1'b0, 4'(k));
            tick;
            if (k >= 2) begin
                check("b2b_ovld", o_vld, 1);
                check("b2b_tag", o_tag, k - 2);
                check("b2b_res", {grt, lst, eq}, t4_exp[k-2]);
            end
        end
        i_vld = 1'b0;
        for (int k = 2; k < 4; k++) begin
            tick;
            check("b2b_ovld", o_vld, 1);
            check("b2b_tag", o_tag, k);
            check("b2b_res", {grt, lst, eq}, t4_exp[k]);
        end
        tick;
        check("b2b_done", o_vld, 0);

        // backpressure: fill with o_rdy low, hold, then drain
        o_rdy = 1'b0;
        op(8'd5, 8'd7, 1'b0, 4'd5); tick;
        op(8'd6, 8'd7, 1'b0, 4'd6); tick;
        op(8'd7, 8'd7, 1'b0, 4'd7); tick;
        op(8'd8, 8'd7, 1'b0, 4'd8);
        check("full_irdy", i_rdy, 0);
        check("full_ovld", o_vld, 1);
        check("full_tag", o_tag, 5);
        tick; tick;
        check("hold_irdy", i_rdy, 0);
        check("hold_ovld", o_vld, 1);
        check("hold_tag", o_tag, 5);
        check("hold_res", {grt, lst, eq}, LST);
        o_rdy = 1'b1;
        #1;
        check("release_irdy", i_rdy, 1);
        tick;
        check("drain_tag6", o_tag, 6);
        check("drain_res6", {grt, lst, eq}, LST);
        op(8'd9, 8'd7, 1'b0, 4'd9); tick;
        check("drain_tag7", o_tag, 7);
        check("drain_res7", {grt, lst, eq}, EQ);
        op(8'd10, 8'd7, 1'b0, 4'd10); tick;
        check("drain_tag8", o_tag, 8);
        check("drain_res8", {grt, lst, eq}, GRT);
        i_vld = 1'b0; tick;
        check("resume_tag9", o_tag, 9);
        check("resume_ovld9", o_vld, 1);
        tick;
        check("resume_tag10", o_tag, 10);
        check("resume_ovld10", o_vld, 1);
        tick;
        check("resume_empty", o_vld, 0);

        // reset with two ops in flight
        op(8'd1, 8'd0, 1'b0, 4'd11); tick;
        op(8'd0, 8'd1, 1'b0, 4'd12); tick;
        i_vld = 1'b0;
        rst = 1'b1; tick;
        check("flush_ovld", o_vld, 0);
        check("flush_tag", o_tag, 0);
        check("flush_res", {grt, lst, eq}, 3'b000);
        check("flush_irdy", i_rdy, 1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("flush_none", o_vld, 0);
        end

        // combinational instance against a behavioural compare
        for (int k = 0; k < 20; k++) begin
            c_val  = 8'($urandom);
            c_rfr  = 8'($urandom);
            c_sgn  = 1'($urandom_range(0, 1));
            if (k % 5 == 0) c_rfr = c_val;
            if (k == 1) begin c_val = 8'h80; c_rfr = 8'h7F; c_sgn = 1'b1; end
            if (k == 2) begin c_val = 8'h80; c_rfr = 8'h7F; c_sgn = 1'b0; end
            c_ordy = 1'($urandom_range(0, 1));
            c_ivld = 1'b1;
            c_itag = 4'(k);
            #1;
            if (c_sgn)
                exp = ($signed(c_val) > $signed(c_rfr)) ? GRT :
                      ($signed(c_val) < $signed(c_rfr)) ? LST : EQ;
            else
                exp = (c_val > c_rfr) ? GRT : (c_val < c_rfr) ? LST : EQ;
            check("comb_res", {c_grt, c_lst, c_eq}, exp);
            check("comb_irdy", c_irdy, c_ordy);
            check("comb_ovld", c_ovld, 1);
            check("comb_tag", c_otag, k % 16);
        end
        c_ivld = 1'b0;
        c_ordy = 1'b1;
        #1;
        check("comb_idle_ovld", c_ovld, 0);
        check("comb_idle_irdy", c_irdy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
